// File: rtl/delay_and_sum_pkg.sv
// Shared width and output-range helpers for the DelayAndSum multiplier pipeline.
package delay_and_sum_pkg;

  // Range limits are carried at this width; DOUT_WIDTH must stay below it.
  localparam int unsigned LIMIT_W = 64;

  function automatic int unsigned prod_width(input int unsigned w0, input int unsigned w1);
    return w0 + w1 + 1;
  endfunction

  function automatic logic signed [LIMIT_W-1:0] out_max(input int unsigned dw, input bit sgn);
    logic signed [LIMIT_W-1:0] one;
    one = LIMIT_W'(1);
    return sgn ? (one << (dw - 1)) - one : (one << dw) - one;
  endfunction

  function automatic logic signed [LIMIT_W-1:0] out_min(input int unsigned dw, input bit sgn);
    logic signed [LIMIT_W-1:0] one;
    one = LIMIT_W'(1);
    return sgn ? -(one << (dw - 1)) : '0;
  endfunction

endpackage

// File: rtl/delay_and_sum_mul_scale.sv
// Combinational post-scale: optional round-half-up, arithmetic right shift, clamp or wrap.
module delay_and_sum_mul_scale
  import delay_and_sum_pkg::*;
#(
  parameter int unsigned P_WIDTH    = 31,
  parameter int unsigned DOUT_WIDTH = 29,
  parameter int unsigned SHIFT      = 0,
  parameter int unsigned ROUND      = 0,
  parameter int unsigned SAT        = 0,
  parameter bit          OUT_SIGNED = 1'b0
) (
  input  logic signed [P_WIDTH-1:0] p,
  output logic [DOUT_WIDTH-1:0]     dout_c,
  output logic                      ovf_c
);

  // One bit of headroom so the rounding add cannot overflow.
  localparam int unsigned SW      = P_WIDTH + 1;
  localparam int unsigned CW      = (SW > LIMIT_W) ? SW : LIMIT_W;
  localparam int unsigned RND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [SW-1:0] RND =
    ((ROUND != 0) && (SHIFT > 0)) ? (SW'(1) << RND_POS) : SW'(0);
  localparam logic signed [CW-1:0] HI = CW'(out_max(DOUT_WIDTH, OUT_SIGNED));
  localparam logic signed [CW-1:0] LO = CW'(out_min(DOUT_WIDTH, OUT_SIGNED));

  logic signed [SW-1:0] sum;
  logic signed [SW-1:0] r;
  logic signed [CW-1:0] r_ext;

  always_comb begin
    sum    = SW'(p) + RND;
    r      = sum >>> SHIFT;
    r_ext  = CW'(r);
    dout_c = r_ext[DOUT_WIDTH-1:0];
    ovf_c  = 1'b0;
    if (r_ext > HI) begin
      ovf_c = 1'b1;
      if (SAT != 0) dout_c = HI[DOUT_WIDTH-1:0];
    end else if (r_ext < LO) begin
      ovf_c = 1'b1;
      if (SAT != 0) dout_c = LO[DOUT_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/delay_and_sum_mul_pipe.sv
// Pipelined signed/unsigned multiplier with valid/ready flow control and collapsing bubbles.
module delay_and_sum_mul_pipe
  import delay_and_sum_pkg::*;
#(
  parameter int unsigned DIN0_WIDTH  = 12,
  parameter int unsigned DIN1_WIDTH  = 18,
  parameter int unsigned DOUT_WIDTH  = 29,
  parameter int unsigned NUM_STAGE   = 3,
  parameter int unsigned DIN0_SIGNED = 0,
  parameter int unsigned DIN1_SIGNED = 0,
  parameter int unsigned SHIFT       = 0,
  parameter int unsigned ROUND       = 0,
  parameter int unsigned SAT         = 0
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic                  ovf
);

  localparam int unsigned A_W        = DIN0_WIDTH + 1;
  localparam int unsigned B_W        = DIN1_WIDTH + 1;
  localparam int unsigned P_W        = prod_width(DIN0_WIDTH, DIN1_WIDTH);
  localparam int unsigned LAST       = NUM_STAGE - 1;
  localparam bit          OUT_SIGNED = (DIN0_SIGNED != 0) || (DIN1_SIGNED != 0);

  logic [NUM_STAGE-1:0]  v;
  logic [NUM_STAGE-1:0]  v_nxt;
  logic [NUM_STAGE-1:0]  adv;
  logic [NUM_STAGE-1:0]  ld;
  logic signed [A_W-1:0] a_ext;
  logic signed [B_W-1:0] b_ext;
  logic signed [P_W-1:0] p_last;
  logic [DOUT_WIDTH-1:0] dout_c;
  logic                  ovf_c;

  assign a_ext = {(DIN0_SIGNED != 0) & din0[DIN0_WIDTH-1], din0};
  assign b_ext = {(DIN1_SIGNED != 0) & din1[DIN1_WIDTH-1], din1};

  // A slot may advance unless it and every slot downstream are full and out_ready is low.
  always_comb begin
    logic all_full;
    adv      = '0;
    all_full = 1'b1;
    for (int k = int'(LAST); k >= 0; k--) begin
      all_full = all_full & v[k];
      adv[k]   = out_ready | ~all_full;
    end
  end

  // ld marks slots that capture a real sample this cycle; data registers only move then.
  always_comb begin
    v_nxt    = v;
    ld       = '0;
    ld[0]    = adv[0] & in_valid;
    v_nxt[0] = adv[0] ? in_valid : v[0];
    for (int k = 1; k < int'(NUM_STAGE); k++) begin
      ld[k]    = adv[k] & v[k-1];
      v_nxt[k] = adv[k] ? v[k-1] : v[k];
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) v <= '0;
    else        v <= v_nxt;
  end

  generate
    if (NUM_STAGE == 1) begin : g_one
      assign p_last = P_W'(a_ext) * P_W'(b_ext);
    end else begin : g_multi
      logic signed [A_W-1:0] a_q;
      logic signed [B_W-1:0] b_q;

      always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (ld[0]) begin
          a_q <= a_ext;
          b_q <= b_ext;
        end
      end

      if (NUM_STAGE == 2) begin : g_two
        assign p_last = P_W'(a_q) * P_W'(b_q);
      end else begin : g_deep
        logic signed [P_W-1:0] p_q [1:NUM_STAGE-2];

        // Slot 1 holds the exact product; further middle slots just delay it.
        always_ff @(posedge ap_clk or posedge ap_rst) begin
          if (ap_rst) begin
            for (int k = 1; k <= int'(NUM_STAGE) - 2; k++) p_q[k] <= '0;
          end else begin
            if (ld[1]) p_q[1] <= P_W'(a_q) * P_W'(b_q);
            for (int k = 2; k <= int'(NUM_STAGE) - 2; k++) begin
              if (ld[k]) p_q[k] <= p_q[k-1];
            end
          end
        end

        assign p_last = p_q[NUM_STAGE-2];
      end
    end
  endgenerate

  delay_and_sum_mul_scale #(
    .P_WIDTH   (P_W),
    .DOUT_WIDTH(DOUT_WIDTH),
    .SHIFT     (SHIFT),
    .ROUND     (ROUND),
    .SAT       (SAT),
    .OUT_SIGNED(OUT_SIGNED)
  ) u_scale (
    .p     (p_last),
    .dout_c(dout_c),
    .ovf_c (ovf_c)
  );

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      dout <= '0;
      ovf  <= 1'b0;
    end else if (ld[LAST]) begin
      dout <= dout_c;
      ovf  <= ovf_c;
    end
  end

  assign out_valid = v[LAST];
  assign in_ready  = adv[0];

endmodule

// File: tb/tb_delay_and_sum_mul_pipe.sv
// Self-checking bench: four configurations share one handshake and are checked against a queue model.
module tb_delay_and_sum_mul_pipe;

  localparam int NI = 4;
  localparam int NS = 3;
  localparam bit SGN [NI] = '{1'b0, 1'b0, 1'b1, 1'b1};
  localparam bit SAT [NI] = '{1'b0, 1'b1, 1'b1, 1'b1};
  localparam bit RND [NI] = '{1'b0, 1'b0, 1'b0, 1'b1};
  localparam int SHF [NI] = '{0, 0, 0, 4};

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [11:0] din0;
  logic [17:0] din1;
  logic [NI-1:0] in_ready;
  logic [NI-1:0] out_valid;
  logic [NI-1:0] ovf;
  logic [28:0] dout [NI];

  int n_cmp = 0;
  int n_err = 0;
  int in_cnt = 0;
  int out_cnt = 0;
  logic [29:0] sbq [$];

  always #5 clk = ~clk;

  delay_and_sum_mul_pipe u0 (
    .ap_clk(clk), .ap_rst(rst), .in_valid(in_valid), .in_ready(in_ready[0]),
    .din0(din0), .din1(din1), .out_valid(out_valid[0]), .out_ready(out_ready),
    .dout(dout[0]), .ovf(ovf[0]));

  delay_and_sum_mul_pipe #(.SAT(1)) u1 (
    .ap_clk(clk), .ap_rst(rst), .in_valid(in_valid), .in_ready(in_ready[1]),
    .din0(din0), .din1(din1), .out_valid(out_valid[1]), .out_ready(out_ready),
    .dout(dout[1]), .ovf(ovf[1]));

  delay_and_sum_mul_pipe #(.DIN0_SIGNED(1), .DIN1_SIGNED(1), .SAT(1)) u2 (
    .ap_clk(clk), .ap_rst(rst), .in_valid(in_valid), .in_ready(in_ready[2]),
    .din0(din0), .din1(din1), .out_valid(out_valid[2]), .out_ready(out_ready),
    .dout(dout[2]), .ovf(ovf[2]));

  delay_and_sum_mul_pipe #(.DIN0_SIGNED(1), .DIN1_SIGNED(1), .SHIFT(4), .ROUND(1), .SAT(1)) u3 (
    .ap_clk(clk), .ap_rst(rst), .in_valid(in_valid), .in_ready(in_ready[3]),
    .din0(din0), .din1(din1), .out_valid(out_valid[3]), .out_ready(out_ready),
    .dout(dout[3]), .ovf(ovf[3]));

  // Reference: exact integer product, scaled and range-checked with plain 64-bit arithmetic.
  function automatic logic [29:0] model(input int i, input logic [11:0] a, input logic [17:0] b);
    longint av, bv, r, lo, hi, d;
    bit o;
    av = SGN[i] ? longint'($signed(a)) : longint'(a);
    bv = SGN[i] ? longint'($signed(b)) : longint'(b);
    r = av * bv;
    if (RND[i] && SHF[i] > 0) r = r + (longint'(1) << (SHF[i] - 1));
    r = r >>> SHF[i];
    lo = SGN[i] ? -(longint'(1) << 28) : 0;
    hi = SGN[i] ? (longint'(1) << 28) - 1 : (longint'(1) << 29) - 1;
    o = (r < lo) || (r > hi);
    d = (o && SAT[i]) ? ((r < lo) ? lo : hi) : r;
    return {o, 29'(d)};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Scoreboard: every output transfer must match the oldest accepted sample, for all configs.
  always @(negedge clk) begin
    if (rst) begin
      sbq.delete();
    end else begin
      if (out_valid[0] && out_ready) begin
        out_cnt++;
        if (sbq.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL sb_extra: got an output with no pending input");
        end else begin
          logic [29:0] item;
          item = sbq.pop_front();
          for (int i = 0; i < NI; i++) begin
            logic [29:0] e;
            e = model(i, item[29:18], item[17:0]);
            check($sformatf("sb_valid%0d", i), 64'(out_valid[i]), 64'(1));
            check($sformatf("sb_dout%0d", i), 64'(dout[i]), 64'(e[28:0]));
            check($sformatf("sb_ovf%0d", i), 64'(ovf[i]), 64'(e[29]));
          end
        end
      end
      if (in_valid && (&in_ready)) begin
        in_cnt++;
        sbq.push_back({din0, din1});
      end
    end
  end

  task automatic wait_out(input int max_cyc);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      if (out_valid[0]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_out: no out_valid within %0d cycles", max_cyc);
    end
  endtask

  task automatic drain(input string name, input int max_cyc);
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int c = 0; c < max_cyc && sbq.size() != 0; c++) @(negedge clk);
    check(name, 64'(sbq.size()), 64'(0));
  endtask

  typedef struct {
    int          inst;
    logic [11:0] a;
    logic [17:0] b;
    logic [28:0] d;
    logic        o;
  } vec_t;

  vec_t tbl [10];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_in, base_out;

    tbl[0] = '{0, 12'd100,   18'd200,    29'd20000,     1'b0};
    tbl[1] = '{1, 12'd4095,  18'd262143, 29'd536870911, 1'b1};
    tbl[2] = '{0, 12'd4095,  18'd262143, 29'd536604673, 1'b1};
    tbl[3] = '{2, 12'hFFD,   18'd5,      29'(-15),      1'b0};
    tbl[4] = '{2, 12'h800,   18'h20000,  29'd268435455, 1'b1};
    tbl[5] = '{3, 12'd3,     18'd6,      29'd1,         1'b0};
    tbl[6] = '{3, 12'd3,     18'd5,      29'd1,         1'b0};
    tbl[7] = '{3, 12'd1,     18'd7,      29'd0,         1'b0};
    tbl[8] = '{3, 12'hFFE,   18'd4,      29'd0,         1'b0};
    tbl[9] = '{3, 12'hFFD,   18'd3,      29'(-1),       1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; din0 = '0; din1 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("rst_valid%0d", i), 64'(out_valid[i]), 64'(0));
      check($sformatf("rst_dout%0d", i), 64'(dout[i]), 64'(0));
      check($sformatf("rst_ovf%0d", i), 64'(ovf[i]), 64'(0));
      check($sformatf("rst_in_ready%0d", i), 64'(in_ready[i]), 64'(1));
    end
    @(posedge clk) #1 rst = 1'b0;

    // Single samples: latency of NS edges including capture, then the tabulated result.
    for (int t = 0; t < 10; t++) begin
      @(posedge clk) #1;
      in_valid = 1'b1; din0 = tbl[t].a; din1 = tbl[t].b;
      @(posedge clk) #1 in_valid = 1'b0;
      for (int e = 1; e < NS; e++) begin
        @(negedge clk);
        check($sformatf("lat_early_v%0d_e%0d", t, e), 64'(out_valid[tbl[t].inst]), 64'(0));
      end
      @(negedge clk);
      check($sformatf("tbl_valid%0d", t), 64'(out_valid[tbl[t].inst]), 64'(1));
      check($sformatf("tbl_dout%0d", t), 64'(dout[tbl[t].inst]), 64'(tbl[t].d));
      check($sformatf("tbl_ovf%0d", t), 64'(ovf[tbl[t].inst]), 64'(tbl[t].o));
    end

    // Eight back-to-back samples stream out on consecutive cycles.
    @(posedge clk) #1;
    fork
      begin
        for (int k = 0; k < 8; k++) begin
          in_valid = 1'b1; din0 = 12'(k); din1 = 18'(1000 + k);
          @(posedge clk) #1;
        end
        in_valid = 1'b0;
      end
      begin
        wait_out(20);
        for (int k = 0; k < 8; k++) begin
          check($sformatf("b2b_valid%0d", k), 64'(out_valid[0]), 64'(1));
          check($sformatf("b2b_dout%0d", k), 64'(dout[0]), 64'(k * (1000 + k)));
          @(negedge clk);
        end
      end
    join
    drain("b2b_drain", 20);

    // Stall with continuous input: exactly NS accepted, outputs held stable.
    @(posedge clk) #1;
    out_ready = 1'b0;
    base_in = in_cnt; base_out = out_cnt;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'b1; din0 = 12'($urandom); din1 = 18'($urandom);
      @(posedge clk) #1;
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("stall_accepted", 64'(in_cnt - base_in), 64'(NS));
      check("stall_in_ready", 64'(in_ready[0]), 64'(0));
      check("stall_valid", 64'(out_valid[0]), 64'(1));
      if (sbq.size() != 0) check("stall_dout", 64'(dout[1]), 64'(model(1, sbq[0][29:18], sbq[0][17:0]) & 30'h1FFFFFFF));
    end
    @(posedge clk) #1;
    drain("stall_drain", 20);
    check("stall_out_count", 64'(out_cnt - base_out), 64'(NS));

    // Gapped input under a stall: bubbles collapse so the pipeline still fills.
    @(posedge clk) #1;
    out_ready = 1'b0;
    base_in = in_cnt;
    for (int c = 0; c < 10; c++) begin
      in_valid = (c % 2) == 0; din0 = 12'($urandom); din1 = 18'($urandom);
      @(posedge clk) #1;
    end
    in_valid = 1'b1;
    @(negedge clk);
    check("bubble_accepted", 64'(in_cnt - base_in), 64'(NS));
    check("bubble_in_ready", 64'(in_ready[0]), 64'(0));
    @(posedge clk) #1;
    drain("bubble_drain", 20);

    // Reset mid-stream clears outputs at once; the first later output is the first later input.
    @(posedge clk) #1;
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1; din0 = 12'($urandom); din1 = 18'($urandom);
      @(posedge clk) #1;
    end
    rst = 1'b1; in_valid = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      check($sformatf("mid_rst_valid%0d", i), 64'(out_valid[i]), 64'(0));
      check($sformatf("mid_rst_dout%0d", i), 64'(dout[i]), 64'(0));
      check($sformatf("mid_rst_ovf%0d", i), 64'(ovf[i]), 64'(0));
    end
    @(posedge clk) #1 rst = 1'b0;
    @(posedge clk) #1;
    in_valid = 1'b1; din0 = 12'd7; din1 = 18'd9;
    @(posedge clk) #1 in_valid = 1'b0;
    wait_out(10);
    check("post_rst_dout", 64'(dout[0]), 64'(63));
    @(posedge clk) #1;

    // Random traffic with random backpressure.
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      din0 = 12'($urandom);
      din1 = 18'($urandom);
      @(posedge clk) #1;
    end
    drain("rand_drain", 40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
